m_wb_uart: RTL and testbench
============================

// Module: m_wb_uart
// PURPOSE
//  Wishbone B4 classic responder UART for the midgetv core: replaces bit-banged serial I/O with
//  hardware TX serializer and RX deserializer (8N1, LSB first). Sits on the core's CYC/STB/WE/ADR/DAT
//  bus next to the LED port. Drives usartTX, samples usartRX, raises an RX-available interrupt (meip).
// PARAMETERS
//  CLKDIV   208  clocks per bit (24 MHz / 115200); legal 8..65535
//  RXDEPTH  4    RX FIFO depth, power of two; used only with M_WB_UART_RXFIFO_EN
// PORTS
//  CLK_I      in   1   system clock (HFOSC, 24 MHz)
//  RST_N_I    in   1   asynchronous active-low reset
//  CYC_I      in   1   Wishbone cycle
//  STB_I      in   1   Wishbone strobe
//  WE_I       in   1   1 = write
//  ADR_I      in   1   register select (byte address bit 2): 0 = DATA, 1 = STATUS
//  DAT_I      in   32  write data; only [7:0] used
//  SEL_I      in   4   byte selects; SEL_I[0] must be set for a DATA write to take effect
//  DAT_O      out  32  read data, [31:8] always 0
//  ACK_O      out  1   Wishbone acknowledge
//  usartRX    in   1   serial input, asynchronous
//  usartTX    out  1   serial output, idle high
//  irq_rx     out  1   level: RX data available
// BEHAVIOUR
//  Reset: usartTX=1, ACK_O=0, DAT_O=0, irq_rx=0, all flags clear, FIFO empty, both FSMs IDLE.
//  Bus: ACK_O is registered; it rises 1 clk after CYC_I&STB_I (when not stalled) for exactly 1 clk.
//   No back-to-back ACK: ACK_O=0 in the cycle after any ACK. DAT_O valid while ACK_O=1, else 0.
//   Write DATA while TX busy: wait-state (ACK held low) until TX returns to IDLE, then accept.
//   Read DATA: returns oldest RX byte and pops it in the ACK cycle; if empty returns 0, no pop.
//   STATUS read: [0] rx_valid, [1] tx_busy, [2] overrun, [3] framing_err, rest 0.
//   STATUS write: 1 to bit 2/3 clears that flag; other bits ignored. Setting event in same clk wins.
//   CYC_I dropped during a wait state aborts the access: no ACK, no side effect.
//  TX FSM: IDLE -> START (1 bit of 0) -> DATA (8 bits, LSB first) -> STOP (1 bit of 1) -> IDLE.
//   Each bit exactly CLKDIV clocks; usartTX goes low the clock after the accepting ACK.
//   tx_busy = (state != IDLE).
//  RX FSM: 2-FF synchronizer on usartRX. IDLE: falling edge -> START; sample at CLKDIV/2;
//   if line high there, false start -> IDLE. DATA: sample 8 bits at CLKDIV intervals. STOP:
//   sample; 1 -> push byte; 0 -> set framing_err, byte discarded, wait for line high, then IDLE.
//   Push when storage full: byte dropped, overrun set, stored data untouched.
//   Same-clock push and pop: both happen, count unchanged (FIFO) / byte replaced (1-entry).
//  irq_rx = rx_valid (storage non-empty). Counters are free-running mod CLKDIV, reload at bit edges.
//  Reset mid-frame: TX line returns to 1 immediately (async), partial RX byte discarded.
// CONFIGURATION
//  M_WB_UART_RXFIFO_EN defined: RX storage is a RXDEPTH-entry FIFO (wrap-around pointers,
//   extra pointer bit for full/empty). Undefined: single holding register; RXDEPTH ignored.
// STRUCTURE
//  Shared include m_wb_uart_defs.vh: register indices (DATA=0, STATUS=1), STATUS bit positions,
//   TX/RX state encodings. Sub-module m_uart_rx (synchronizer + RX FSM, outputs byte+push+ferr).
//   TX FSM, bus logic and storage stay in m_wb_uart.
// TESTING
//  Write DATA 0x55 at CLKDIV=16 -> usartTX: 0,1,0,1,0,1,0,1,0,1 each 16 clk, then idle 1; tx_busy 1 during.
//  Write 0xA3 then 0x0F back-to-back -> second ACK stalled until first stop bit ends; both frames intact.
//  Drive RX frame 0x3C -> irq_rx=1, STATUS=0x1, DATA read returns 0x3C, then irq_rx=0, STATUS=0x0.
//  RX frame with stop bit 0 -> STATUS[3]=1, no data; write STATUS 0x8 -> STATUS=0x0.
//  5 frames 0x01..0x05 unread -> FIFO build: reads 0x01..0x04, overrun=1; non-FIFO: 0x01, overrun=1.
//  0.25-bit low glitch on usartRX -> no byte, no flags; RST_N_I low mid-TX -> usartTX=1 same cycle.

Source files
------------

// File: rtl/m_wb_uart_pkg.sv
// m_wb_uart_pkg: shared definitions for the Wishbone UART.
//   Register indices (ADR_I), STATUS bit positions, TX/RX FSM state encodings
//   and the bit-timer width.
`timescale 1ns/1ps
package m_wb_uart_pkg;

  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int ST_RX_VALID = 0;
  localparam int ST_TX_BUSY  = 1;
  localparam int ST_OVERRUN  = 2;
  localparam int ST_FERR     = 3;

  // Bit timer width; covers CLKDIV up to 65535.
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

endpackage

// File: rtl/m_wb_uart_rx.sv
// m_uart_rx: 8N1 serial receiver, LSB first.
//   clklf     in  system clock
//   rst_n     in  asynchronous active-low reset
//   rx_async  in  serial line, asynchronous to clklf
//   rx_byte   out received byte, stable while rx_push is high
//   rx_push   out 1-clk pulse: rx_byte holds a good frame
//   rx_ferr   out 1-clk pulse: stop bit sampled low, byte discarded
//
// state    | meaning
// RX_IDLE  | line idle, waiting for a falling edge
// RX_START | timing half a bit to mid-start; high there = false start
// RX_DATA  | sampling 8 data bits, one per CLKDIV clocks
// RX_STOP  | sampling stop bit
// RX_BREAK | framing error seen, waiting for the line to return high
`timescale 1ns/1ps
module m_uart_rx
  import m_wb_uart_pkg::*;
#(
  parameter int CLKDIV = 208
) (
  input  logic       clklf,
  input  logic       rst_n,
  input  logic       rx_async,
  output logic [7:0] rx_byte,
  output logic       rx_push,
  output logic       rx_ferr
);

  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(CLKDIV - 1);
  localparam logic [CNT_W-1:0] HALF_TOP = CNT_W'(CLKDIV / 2 - 1);

  logic rx_meta, rx_s, rx_prev;

  rx_state_e        rx_state, rx_state_nxt;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
  logic [2:0]       rx_bit, rx_bit_nxt;
  logic [7:0]       rx_shift, rx_shift_nxt;
  logic             push_nxt, ferr_nxt;

  // Synchronizer resets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clklf or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_async;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clklf or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= HALF_TOP;
      rx_bit   <= 3'd0;
      rx_shift <= 8'h00;
      rx_push  <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_bit   <= rx_bit_nxt;
      rx_shift <= rx_shift_nxt;
      rx_push  <= push_nxt;
      rx_ferr  <= ferr_nxt;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = (rx_cnt == '0) ? CNT_TOP : rx_cnt - CNT_W'(1);
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    push_nxt     = 1'b0;
    ferr_nxt     = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_nxt = HALF_TOP;
        if (rx_prev && !rx_s) rx_state_nxt = RX_START;
      end
      RX_START: begin
        if (rx_cnt == '0) begin
          rx_bit_nxt   = 3'd0;
          rx_state_nxt = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == '0) begin
          rx_shift_nxt = {rx_s, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
          else                rx_bit_nxt   = rx_bit + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == '0) begin
          if (rx_s) begin
            push_nxt     = 1'b1;
            rx_state_nxt = RX_IDLE;
          end else begin
            ferr_nxt     = 1'b1;
            rx_state_nxt = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        if (rx_s) rx_state_nxt = RX_IDLE;
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  assign rx_byte = rx_shift;

endmodule

// File: rtl/m_wb_uart.sv
// m_wb_uart: Wishbone B4 classic responder UART (8N1, LSB first).
//   CLK_I, RST_N_I       clock, asynchronous active-low reset
//   CYC_I STB_I WE_I     bus cycle / strobe / write
//   ADR_I                0 = DATA, 1 = STATUS
//   DAT_I[31:0] SEL_I    write data ([7:0] used), byte selects (SEL_I[0] gates DATA writes)
//   DAT_O[31:0] ACK_O    read data (0 outside ACK), registered acknowledge
//   usartRX usartTX      serial in (async) / serial out (idle high)
//   irq_rx               level, RX data available
// Build option: define M_WB_UART_RXFIFO_EN for an RXDEPTH-entry RX FIFO;
// otherwise RX storage is a single holding register.
//
// state    | meaning
// TX_IDLE  | line high, ready to accept a DATA write
// TX_START | start bit (0) for CLKDIV clocks
// TX_DATA  | 8 data bits, LSB first
// TX_STOP  | stop bit (1)
`timescale 1ns/1ps
module m_wb_uart
  import m_wb_uart_pkg::*;
#(
  parameter int CLKDIV  = 208,
  parameter int RXDEPTH = 4
) (
  input  logic        CLK_I,
  input  logic        RST_N_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic        ADR_I,
  input  logic [31:0] DAT_I,
  input  logic [3:0]  SEL_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  input  logic        usartRX,
  output logic        usartTX,
  output logic        irq_rx
);

  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CLKDIV - 1);

  logic        unused_bits;
  assign unused_bits = ^{DAT_I[31:8], SEL_I[3:1]};

  tx_state_e        tx_state, tx_state_nxt;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_nxt;
  logic [2:0]       tx_bit, tx_bit_nxt;
  logic [7:0]       tx_shift, tx_shift_nxt;
  logic             tx_line_nxt, tx_busy;

  logic [7:0]  rx_byte, rx_head;
  logic        rx_push, rx_ferr, rx_valid, push_ok, ovr_set;
  logic        overrun, ferr;

  logic        is_data, req, stall, accept, tx_start, pop, stat_wr;
  logic [31:0] rd_data;

  // ---------------- bus ----------------
  assign is_data  = (ADR_I == REG_DATA);
  // ~ACK_O keeps a dead cycle after every acknowledge.
  assign req      = CYC_I & STB_I & ~ACK_O;
  assign stall    = WE_I & is_data & tx_busy;
  assign accept   = req & ~stall;
  assign tx_start = accept & WE_I & is_data & SEL_I[0];
  assign pop      = accept & ~WE_I & is_data & rx_valid;
  assign stat_wr  = accept & WE_I & ~is_data;

  always_comb begin
    rd_data = '0;
    if (is_data) begin
      if (rx_valid) rd_data[7:0] = rx_head;
    end else begin
      rd_data[ST_RX_VALID] = rx_valid;
      rd_data[ST_TX_BUSY]  = tx_busy;
      rd_data[ST_OVERRUN]  = overrun;
      rd_data[ST_FERR]     = ferr;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      ACK_O <= 1'b0;
      DAT_O <= '0;
    end else begin
      ACK_O <= accept;
      DAT_O <= (accept & ~WE_I) ? rd_data : '0;
    end
  end

  // Sticky flags: a new event in the same clock as a clear wins.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      overrun <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      overrun <= ovr_set | (overrun & ~(stat_wr & DAT_I[ST_OVERRUN]));
      ferr    <= rx_ferr | (ferr & ~(stat_wr & DAT_I[ST_FERR]));
    end
  end

  // ---------------- TX ----------------
  assign tx_busy = (tx_state != TX_IDLE);

  // usartTX is registered from the state, so the line trails the FSM by one clock.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= CNT_TOP;
      tx_bit   <= 3'd0;
      tx_shift <= 8'h00;
      usartTX  <= 1'b1;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_shift <= tx_shift_nxt;
      usartTX  <= tx_line_nxt;
    end
  end

  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = (tx_cnt == '0) ? CNT_TOP : tx_cnt - CNT_W'(1);
    tx_bit_nxt   = tx_bit;
    tx_shift_nxt = tx_shift;
    tx_line_nxt  = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_nxt = CNT_TOP;
        if (tx_start) begin
          tx_shift_nxt = DAT_I[7:0];
          tx_state_nxt = TX_START;
        end
      end
      TX_START: begin
        tx_line_nxt = 1'b0;
        if (tx_cnt == '0) begin
          tx_bit_nxt   = 3'd0;
          tx_state_nxt = TX_DATA;
        end
      end
      TX_DATA: begin
        tx_line_nxt = tx_shift[0];
        if (tx_cnt == '0) begin
          tx_shift_nxt = {1'b0, tx_shift[7:1]};
          if (tx_bit == 3'd7) tx_state_nxt = TX_STOP;
          else                tx_bit_nxt   = tx_bit + 3'd1;
        end
      end
      TX_STOP: begin
        if (tx_cnt == '0) tx_state_nxt = TX_IDLE;
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  // ---------------- RX ----------------
  m_uart_rx #(.CLKDIV(CLKDIV)) u_rx (
    .clklf    (CLK_I),
    .rst_n    (RST_N_I),
    .rx_async (usartRX),
    .rx_byte  (rx_byte),
    .rx_push  (rx_push),
    .rx_ferr  (rx_ferr)
  );

`ifdef M_WB_UART_RXFIFO_EN
  localparam int AW = $clog2(RXDEPTH);

  logic [7:0]  fifo_mem [RXDEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_full;

  // Extra pointer MSB distinguishes full from empty.
  assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rx_valid  = (wr_ptr != rd_ptr);
  assign rx_head   = fifo_mem[rd_ptr[AW-1:0]];
  // A pop in the same clock frees the slot the push needs.
  assign push_ok   = rx_push & (~fifo_full | pop);
  assign ovr_set   = rx_push & ~push_ok;

  always_ff @(posedge CLK_I) begin
    if (push_ok) fifo_mem[wr_ptr[AW-1:0]] <= rx_byte;
  end

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
`else
  localparam int unused_rxdepth = RXDEPTH;

  logic [7:0] hold_q;
  logic       hold_v;

  assign rx_valid = hold_v;
  assign rx_head  = hold_q;
  // Pop and push together: the new byte replaces the one being read.
  assign push_ok  = rx_push & (~hold_v | pop);
  assign ovr_set  = rx_push & ~push_ok;

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      hold_q <= 8'h00;
      hold_v <= 1'b0;
    end else if (push_ok) begin
      hold_q <= rx_byte;
      hold_v <= 1'b1;
    end else if (pop) begin
      hold_v <= 1'b0;
    end
  end
`endif

  assign irq_rx = rx_valid;

endmodule

// File: tb/tb_m_wb_uart.sv
`timescale 1ns/1ps
module tb_m_wb_uart;

  localparam int CLKDIV = 16;

  logic        CLK_I = 1'b0;
  logic        RST_N_I = 1'b0;
  logic        CYC_I = 1'b0, STB_I = 1'b0, WE_I = 1'b0, ADR_I = 1'b0;
  logic [31:0] DAT_I = '0;
  logic [3:0]  SEL_I = '0;
  logic [31:0] DAT_O;
  logic        ACK_O;
  logic        usartRX = 1'b1;
  logic        usartTX;
  logic        irq_rx;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  tx_exp_q[$];

  m_wb_uart #(.CLKDIV(CLKDIV), .RXDEPTH(4)) dut (
    .CLK_I   (CLK_I),
    .RST_N_I (RST_N_I),
    .CYC_I   (CYC_I),
    .STB_I   (STB_I),
    .WE_I    (WE_I),
    .ADR_I   (ADR_I),
    .DAT_I   (DAT_I),
    .SEL_I   (SEL_I),
    .DAT_O   (DAT_O),
    .ACK_O   (ACK_O),
    .usartRX (usartRX),
    .usartTX (usartTX),
    .irq_rx  (irq_rx)
  );

  always #5 CLK_I = ~CLK_I;
  always @(posedge CLK_I) cyc_cnt++;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at 1 ms, want completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Bus monitor: every ACK pops one expected DAT_O.
  logic ack_prev = 1'b0;
  always @(negedge CLK_I) begin
    if (ACK_O) begin
      chk("ack_gap", {31'b0, ack_prev}, 32'h0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ACK with DAT_O 0x%0h, want no ACK", DAT_O);
      end else begin
        chk("bus_dat_o", DAT_O, exp_q.pop_front());
      end
    end
    ack_prev = ACK_O;
  end

  // TX monitor: decodes frames at mid-bit and pops the expected byte.
  logic [7:0] mon_b;
  logic       mon_stop;
  always begin
    @(negedge usartTX);
    repeat (CLKDIV/2) @(posedge CLK_I);
    #1;
    if (usartTX === 1'b0) begin
      for (int i = 0; i < 8; i++) begin
        repeat (CLKDIV) @(posedge CLK_I);
        #1;
        mon_b[i] = usartTX;
      end
      repeat (CLKDIV) @(posedge CLK_I);
      #1;
      mon_stop = usartTX;
      if (tx_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tx_frame: got byte 0x%0h, want no frame", mon_b);
      end else begin
        chk("tx_frame", {24'b0, mon_b}, {24'b0, tx_exp_q.pop_front()});
        chk("tx_stop", {31'b0, mon_stop}, 32'h1);
      end
    end
  end

  task automatic wb_xfer(input logic we, input logic adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [31:0] exp, output int ack_cyc);
    int  n;
    bit  got;
    n = 0;
    got = 0;
    exp_q.push_back(exp);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = dat; SEL_I = sel;
    while (!got && n < 1000) begin
      @(posedge CLK_I);
      #1;
      n++;
      if (ACK_O) got = 1;
    end
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; DAT_I = '0; SEL_I = '0;
    ack_cyc = cyc_cnt;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL wb_timeout: got no ACK in 1000 clk, want ACK");
      void'(exp_q.pop_back());
    end
  endtask

  task automatic wr(input logic adr, input logic [31:0] dat);
    int t;
    wb_xfer(1'b1, adr, dat, 4'h1, 32'h0, t);
  endtask

  task automatic rd(input logic adr, input logic [31:0] exp);
    int t;
    wb_xfer(1'b0, adr, 32'h0, 4'hf, exp, t);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      usartRX = fr[i];
      repeat (CLKDIV) @(posedge CLK_I);
      #1;
    end
    usartRX = 1'b1;
  endtask

  initial begin
    int         t1, t2, t3;
    int         wave_err;
    bit         ack_seen;
    logic [9:0] fr55;

    repeat (3) @(posedge CLK_I);
    #1;
    chk("rst_usartTX", {31'b0, usartTX}, 32'h1);
    chk("rst_ack", {31'b0, ACK_O}, 32'h0);
    chk("rst_dat_o", DAT_O, 32'h0);
    chk("rst_irq", {31'b0, irq_rx}, 32'h0);
    RST_N_I = 1'b1;
    repeat (2) @(posedge CLK_I);
    #1;
    rd(1'b1, 32'h0);

    // TX 0x55: exact wave, one sample per clock
    fr55 = {1'b1, 8'h55, 1'b0};
    wave_err = 0;
    tx_exp_q.push_back(8'h55);
    wr(1'b0, 32'h55);
    fork
      begin
        for (int k = 0; k < 10*CLKDIV; k++) begin
          @(posedge CLK_I);
          #1;
          if (usartTX !== fr55[k/CLKDIV]) wave_err++;
        end
      end
      begin
        repeat (3*CLKDIV) @(posedge CLK_I);
        #1;
        rd(1'b1, 32'h2);
      end
    join
    chk("tx55_wave_errs", wave_err, 0);
    @(posedge CLK_I);
    #1;
    chk("tx55_idle", {31'b0, usartTX}, 32'h1);
    rd(1'b1, 32'h0);

    // back-to-back writes: second stalls until the first frame is done
    tx_exp_q.push_back(8'hA3);
    tx_exp_q.push_back(8'h0F);
    wb_xfer(1'b1, 1'b0, 32'hA3, 4'h1, 32'h0, t1);
    wb_xfer(1'b1, 1'b0, 32'h0F, 4'h1, 32'h0, t2);
    chk("b2b_stall_clks", t2 - t1, 10*CLKDIV + 1);
    repeat (11*CLKDIV) @(posedge CLK_I);
    #1;
    chk("b2b_frames_seen", tx_exp_q.size(), 0);

    // RX 0x3C
    send_rx(8'h3C, 1'b1);
    repeat (CLKDIV) @(posedge CLK_I);
    #1;
    chk("rx_irq_set", {31'b0, irq_rx}, 32'h1);
    rd(1'b1, 32'h1);
    rd(1'b0, 32'h3C);
    chk("rx_irq_clr", {31'b0, irq_rx}, 32'h0);
    rd(1'b1, 32'h0);

    // framing error
    send_rx(8'hA5, 1'b0);
    repeat (2*CLKDIV) @(posedge CLK_I);
    #1;
    chk("ferr_no_irq", {31'b0, irq_rx}, 32'h0);
    rd(1'b1, 32'h8);
    wr(1'b1, 32'h8);
    rd(1'b1, 32'h0);

    // overrun
    for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b1);
    repeat (CLKDIV) @(posedge CLK_I);
    #1;
    rd(1'b1, 32'h5);
`ifdef M_WB_UART_RXFIFO_EN
    for (int i = 1; i <= 4; i++) rd(1'b0, 32'(i));
`else
    rd(1'b0, 32'h1);
`endif
    rd(1'b1, 32'h4);
    rd(1'b0, 32'h0);
    wr(1'b1, 32'h4);
    rd(1'b1, 32'h0);

    // quarter-bit glitch
    usartRX = 1'b0;
    repeat (CLKDIV/4) @(posedge CLK_I);
    #1;
    usartRX = 1'b1;
    repeat (2*CLKDIV) @(posedge CLK_I);
    #1;
    chk("glitch_irq", {31'b0, irq_rx}, 32'h0);
    rd(1'b1, 32'h0);

    // DATA write without SEL_I[0]: acknowledged, nothing sent
    wb_xfer(1'b1, 1'b0, 32'h77, 4'hE, 32'h0, t3);
    rd(1'b1, 32'h0);

    // abort a stalled write by dropping CYC_I
    tx_exp_q.push_back(8'h11);
    wr(1'b0, 32'h11);
    ack_seen = 0;
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = 1'b0; DAT_I = 32'h22; SEL_I = 4'h1;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK_I);
      #1;
      if (ACK_O) ack_seen = 1;
    end
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; DAT_I = '0; SEL_I = '0;
    chk("abort_no_ack", {31'b0, ack_seen}, 32'h0);
    repeat (11*CLKDIV) @(posedge CLK_I);
    #1;
    chk("abort_frames_seen", tx_exp_q.size(), 0);

    // reset mid-TX
    wr(1'b0, 32'h00);
    repeat (3) @(posedge CLK_I);
    #1;
    chk("midtx_line_low", {31'b0, usartTX}, 32'h0);
    RST_N_I = 1'b0;
    #1;
    chk("midtx_rst_line", {31'b0, usartTX}, 32'h1);
    repeat (2) @(posedge CLK_I);
    #1;
    RST_N_I = 1'b1;
    repeat (2*CLKDIV) @(posedge CLK_I);
    #1;
    chk("post_rst_line", {31'b0, usartTX}, 32'h1);
    rd(1'b1, 32'h0);

    repeat (4) @(posedge CLK_I);
    #1;
    chk("bus_q_drained", exp_q.size(), 0);
    chk("tx_q_drained", tx_exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
